tdc_meas_seq: RTL and testbench

Measurement sequencer that drives a TDC instance and consumes its hamming-weight result. Each measurement fires one launch-edge toggle into the TDC pulse generator, waits the TDC's fixed capture/sync/popcount latency, samples `hw`, and repeats for a burst of 2^LOG2_MEAS samples. It accumulates sum, min and max over the burst and presents them on a valid/ready result port. It is the control/readout side paired with the TDC top level and runs in the capture clock domain.

---
 rtl/tdc_meas_seq.sv | 126 ++++++++++++
 tb/tb_tdc_meas_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_seq.sv
// tdc_meas_seq: burst measurement sequencer for a TDC; accumulates sum/avg (and min/max when
// TDC_SEQ_MINMAX_EN is defined) over 2^LOG2_MEAS hamming-weight samples behind a valid/ready port.
module tdc_meas_seq #(
    parameter int N         = 64,
    parameter int N_SYNC    = 2,
    parameter int PC_LAT    = 1,
    parameter int LOG2_MEAS = 4,
    localparam int HW_W     = $clog2(N) + 1,
    localparam int SUM_W    = $clog2(N) + LOG2_MEAS + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              tdc_en,
    output logic              tdc_pg_tog,
    input  logic [HW_W-1:0]   tdc_hw,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_sum,
    output logic [HW_W-1:0]   res_avg,
    output logic [HW_W-1:0]   res_min,
    output logic [HW_W-1:0]   res_max
);
    localparam int LAT = N_SYNC + PC_LAT;
    localparam int WCW = $clog2(LAT + 1);

    typedef enum logic [2:0] {IDLE, ARM, LAUNCH, WAIT, SAMPLE, DONE} state_t;

    state_t               state_q, state_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic [LOG2_MEAS-1:0] scnt_q, scnt_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic                 busy_q, busy_d, en_q, en_d, tog_q, tog_d, valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        scnt_d  = scnt_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ARM;
                scnt_d  = '0;
                sum_d   = '0;
            end
            ARM: state_d = LAUNCH;
            LAUNCH: begin
                state_d = WAIT;
                wcnt_d  = WCW'(LAT);
            end
            WAIT: begin
                state_d = (wcnt_q == '0) ? SAMPLE : WAIT;
                wcnt_d  = (wcnt_q == '0) ? wcnt_q : wcnt_q - 1'b1;
            end
            SAMPLE: begin
                sum_d   = sum_q + SUM_W'(tdc_hw);
                scnt_d  = scnt_q + 1'b1;
                state_d = (scnt_q == '1) ? DONE : LAUNCH;
            end
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are decoded from the state being entered.
        busy_d  = state_d != IDLE;
        en_d    = state_d inside {ARM, LAUNCH, WAIT, SAMPLE};
        tog_d   = state_d == LAUNCH;
        valid_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            scnt_q  <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            tog_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            tog_q   <= tog_d;
            valid_q <= valid_d;
        end
    end

    assign busy       = busy_q;
    assign tdc_en     = en_q;
    assign tdc_pg_tog = tog_q;
    assign res_valid  = valid_q;
    assign res_sum    = sum_q;
    assign res_avg    = HW_W'(sum_q >> LOG2_MEAS);

`ifdef TDC_SEQ_MINMAX_EN
    logic [HW_W-1:0] min_q, min_d, max_q, max_d;

    always_comb begin
        min_d = (state_q == IDLE && start) ? '1 :
                (state_q == SAMPLE && tdc_hw < min_q) ? tdc_hw : min_q;
        max_d = (state_q == IDLE && start) ? '0 :
                (state_q == SAMPLE && tdc_hw > max_q) ? tdc_hw : max_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign res_min = min_q;
    assign res_max = max_q;
`else
    assign res_min = '0;
    assign res_max = '0;
`endif
endmodule

// File: tb/tb_tdc_meas_seq.sv
// tb_tdc_meas_seq: randomized bench for tdc_meas_seq; sample values are captured at the cycles the
// sequencer timing dictates and reduced to sum/avg/min/max with plain arithmetic.
module tb_tdc_meas_seq;
    localparam int HW_W    = 7;
    localparam int SUM_W   = 11;
    localparam int SUM8_W  = 15;
    localparam int PER     = 6;
    localparam int M       = 16;
    localparam int T_VALID = 2 + M * PER;
    localparam int T8      = 2 + 256 * PER;

    logic              clk = 1'b0, rst = 1'b0, start = 1'b0, start8 = 1'b0, res_ready = 1'b0;
    logic [HW_W-1:0]   tdc_hw = '0;
    logic              busy, tdc_en, tdc_pg_tog, res_valid;
    logic [SUM_W-1:0]  res_sum;
    logic [HW_W-1:0]   res_avg, res_min, res_max;
    logic              busy8, tdc_en8, tdc_pg_tog8, res_valid8;
    logic [SUM8_W-1:0] res_sum8;
    logic [HW_W-1:0]   res_avg8, res_min8, res_max8;
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    tdc_meas_seq dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .tdc_en(tdc_en), .tdc_pg_tog(tdc_pg_tog),
        .tdc_hw(tdc_hw), .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_avg(res_avg), .res_min(res_min), .res_max(res_max)
    );

    tdc_meas_seq #(.LOG2_MEAS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .tdc_en(tdc_en8), .tdc_pg_tog(tdc_pg_tog8),
        .tdc_hw(tdc_hw), .res_valid(res_valid8), .res_ready(res_ready), .res_sum(res_sum8),
        .res_avg(res_avg8), .res_min(res_min8), .res_max(res_max8)
    );

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, tdc_en, tdc_pg_tog, res_valid, res_sum, res_avg, res_min, res_max} !== '0)
            $display("FAIL reset_outputs got=%0h exp=0",
                     {busy, tdc_en, tdc_pg_tog, res_valid, res_sum, res_avg, res_min, res_max});
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, tdc_en, tdc_pg_tog, res_valid} !== 4'b0000)
            $display("FAIL reset_release_ctrl got=%b exp=0000", {busy, tdc_en, tdc_pg_tog, res_valid});
        else n_pass++;
    endtask

    // mode 0: random samples, 1: constant 32, 2: ramp 0..15 by sample index
    task automatic test_burst(input int mode, input int hold, input bit noise_start);
        int samples[$];
        int v, pulses, s_sum, s_min, s_max;
        logic [3:0] exp_ctrl;
        pulses = 0;
        for (int c = 0; c <= T_VALID; c++) begin
            @(negedge clk);
            exp_ctrl = {1'(c >= 1), 1'(c >= 1 && c < T_VALID),
                        1'(c >= 2 && (c - 2) % PER == 0 && (c - 2) / PER < M), 1'(c == T_VALID)};
            n_total++;
            if ({busy, tdc_en, tdc_pg_tog, res_valid} !== exp_ctrl)
                $display("FAIL burst_ctrl mode=%0d c=%0d got=%b exp=%b", mode, c,
                         {busy, tdc_en, tdc_pg_tog, res_valid}, exp_ctrl);
            else n_pass++;
            pulses += int'(tdc_pg_tog);
            start = (c == 0) || (noise_start && $urandom_range(0, 7) == 0);
            if (c >= 7 && (c - 7) % PER == 0 && (c - 7) / PER < M) begin
                v = (mode == 1) ? 32 : (mode == 2) ? (c - 7) / PER : int'($urandom_range(0, 64));
                samples.push_back(v);
                tdc_hw = HW_W'(v);
            end else tdc_hw = HW_W'($urandom_range(0, 127));
        end
        s_sum = 0;
        s_min = 1 << 30;
        s_max = 0;
        foreach (samples[i]) begin
            s_sum += samples[i];
            if (samples[i] < s_min) s_min = samples[i];
            if (samples[i] > s_max) s_max = samples[i];
        end
`ifndef TDC_SEQ_MINMAX_EN
        s_min = 0;
        s_max = 0;
`endif
        n_total++;
        if (res_sum !== SUM_W'(s_sum)) $display("FAIL sum mode=%0d got=%0d exp=%0d", mode, res_sum, s_sum);
        else n_pass++;
        n_total++;
        if (res_avg !== HW_W'(s_sum / M)) $display("FAIL avg mode=%0d got=%0d exp=%0d", mode, res_avg, s_sum / M);
        else n_pass++;
        n_total++;
        if (res_min !== HW_W'(s_min)) $display("FAIL min mode=%0d got=%0d exp=%0d", mode, res_min, s_min);
        else n_pass++;
        n_total++;
        if (res_max !== HW_W'(s_max)) $display("FAIL max mode=%0d got=%0d exp=%0d", mode, res_max, s_max);
        else n_pass++;
        n_total++;
        if (pulses != M) $display("FAIL tog_count mode=%0d got=%0d exp=%0d", mode, pulses, M);
        else n_pass++;
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            start = h[0];
            @(negedge clk);
            n_total++;
            if ({busy, res_valid, res_sum, res_min, res_max} !== {2'b11, SUM_W'(s_sum), HW_W'(s_min), HW_W'(s_max)})
                $display("FAIL done_hold h=%0d got=%b/%0d exp=11/%0d", h, {busy, res_valid}, res_sum, s_sum);
            else n_pass++;
        end
        res_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res_ready = 1'b0;
        n_total++;
        if ({busy, res_valid, res_sum, res_avg} !== {2'b00, SUM_W'(s_sum), HW_W'(s_sum / M)})
            $display("FAIL handshake_idle got=%b/%0d exp=00/%0d", {busy, res_valid}, res_sum, s_sum);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL start_in_done_ignored got=%b exp=0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            start = (c == 0);
            tdc_hw = HW_W'($urandom_range(1, 64));
        end
        n_total++;
        if (busy !== 1'b1 || res_sum == '0) $display("FAIL pre_reset_active busy=%b sum=%0d exp busy=1 sum>0", busy, res_sum);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({busy, tdc_en, tdc_pg_tog, res_valid, res_sum, res_avg, res_min, res_max} !== '0)
            $display("FAIL reset_mid_outputs got=%0h exp=0",
                     {busy, tdc_en, tdc_pg_tog, res_valid, res_sum, res_avg, res_min, res_max});
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if ({busy, tdc_en, tdc_pg_tog, res_valid} !== 4'b0000)
                $display("FAIL post_reset_idle c=%0d got=%b exp=0000", c, {busy, tdc_en, tdc_pg_tog, res_valid});
            else n_pass++;
        end
    endtask

    task automatic test_no_overflow;
        @(negedge clk);
        start8 = 1'b1;
        tdc_hw = HW_W'(64);
        for (int c = 1; c <= T8; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (c == T8 - 1) begin
                n_total++;
                if (res_valid8 !== 1'b0) $display("FAIL l8_early_valid got=%b exp=0", res_valid8);
                else n_pass++;
            end
        end
        n_total++;
        if ({res_valid8, res_sum8, res_avg8} !== {1'b1, SUM8_W'(64 * 256), HW_W'(64)})
            $display("FAIL l8_result valid=%b sum=%0d avg=%0d exp valid=1 sum=16384 avg=64", res_valid8, res_sum8, res_avg8);
        else n_pass++;
        n_total++;
`ifdef TDC_SEQ_MINMAX_EN
        if ({res_min8, res_max8} !== {HW_W'(64), HW_W'(64)})
            $display("FAIL l8_minmax got=%0d/%0d exp=64/64", res_min8, res_max8);
`else
        if ({res_min8, res_max8} !== '0)
            $display("FAIL l8_minmax got=%0d/%0d exp=0/0", res_min8, res_max8);
`endif
        else n_pass++;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_total++;
        if ({busy8, res_valid8} !== 2'b00) $display("FAIL l8_handshake got=%b exp=00", {busy8, res_valid8});
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_burst(1, 10, 1'b0);
        test_burst(2, 0, 1'b0);
        repeat (3) test_burst(0, int'($urandom_range(0, 3)), 1'b1);
        test_reset_mid;
        test_burst(0, 1, 1'b1);
        test_no_overflow;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
